// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the registered ALU control decoder: op codes,
// selector patterns, FSM states and the decoder result record.
package alu_ctrl_pkg;

   localparam logic [3:0] OP_AND      = 4'b0000;
   localparam logic [3:0] OP_OR       = 4'b0001;
   localparam logic [3:0] OP_NOR      = 4'b0010;
   localparam logic [3:0] OP_ADD      = 4'b0011;
   localparam logic [3:0] OP_BEQ      = 4'b0100;
   localparam logic [3:0] OP_NOP      = 4'b1001;
   localparam logic [3:0] OP_MULTPLUS = 4'b1010;
   localparam logic [3:0] OP_MUL_STEP = 4'b1010;
   localparam logic [3:0] OP_MUL_INIT = 4'b1011;
   localparam logic [3:0] OP_MUL_DONE = 4'b1100;
   localparam logic [3:0] OP_INC      = 4'b1111;

   localparam logic [2:0] ALUOP_R    = 3'b111;
   localparam logic [2:0] ALUOP_ADDI = 3'b100;
   localparam logic [2:0] ALUOP_ORI  = 3'b101;
   localparam logic [2:0] ALUOP_BR   = 3'b001;
   localparam logic [2:0] ALUOP_INC  = 3'b110;

   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_MULT = 6'b011000;

   typedef enum logic [1:0] {IDLE, MUL_INIT, MUL_STEP, MUL_DONE} state_t;

   typedef struct packed {
      logic [3:0] code;
      logic       is_mult;
      logic       illegal;
   } dec_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational selector decoder. Comparisons are on the full port width, so
// any set bit above the nominal 3-bit ALUOp / 6-bit funct prevents a match.
module alu_ctrl_decode
   import alu_ctrl_pkg::*;
#(
   parameter int OP_W    = 3,
   parameter int FUNCT_W = 6
) (
   input  logic [OP_W-1:0]    ALUOp,
   input  logic [FUNCT_W-1:0] ALUFunction,
   output dec_t               dec
);

   // Ordered chain: R-type exact functs first, then the R-type catch-all.
   always_comb begin
      dec = '{code: OP_NOP, is_mult: 1'b0, illegal: 1'b0};
      if (ALUOp == OP_W'(ALUOP_R)) begin
         if (ALUFunction == FUNCT_W'(FN_AND))       dec.code = OP_AND;
         else if (ALUFunction == FUNCT_W'(FN_OR))   dec.code = OP_OR;
         else if (ALUFunction == FUNCT_W'(FN_NOR))  dec.code = OP_NOR;
         else if (ALUFunction == FUNCT_W'(FN_ADD))  dec.code = OP_ADD;
         else if (ALUFunction == FUNCT_W'(FN_MULT)) begin
            dec.code    = OP_MUL_INIT;
            dec.is_mult = 1'b1;
         end
         else dec.code = OP_MULTPLUS;
      end
      else if (ALUOp == OP_W'(ALUOP_ADDI)) dec.code = OP_ADD;
      else if (ALUOp == OP_W'(ALUOP_ORI))  dec.code = OP_OR;
      else if (ALUOp == OP_W'(ALUOP_BR))   dec.code = OP_BEQ;
      else if (ALUOp == OP_W'(ALUOP_INC))  dec.code = OP_INC;
      else dec.illegal = 1'b1;
   end

endmodule

// File: rtl/alu_control_seq.sv
// Registered ALU control with multi-cycle MULT sequencing (INIT/STEP*N/DONE).
// Define ALU_CTRL_ILLEGAL_TRAP_EN to trap illegal selectors into sticky IllegalOp.
module alu_control_seq
   import alu_ctrl_pkg::*;
#(
   parameter int OP_W      = 3,
   parameter int FUNCT_W   = 6,
   parameter int CODE_W    = 4,
   parameter int MUL_STEPS = 32,
   parameter int CNT_W     = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               Valid,
   input  logic               Flush,
   input  logic [OP_W-1:0]    ALUOp,
   input  logic [FUNCT_W-1:0] ALUFunction,
   output logic [CODE_W-1:0]  ALUOperation,
   output logic               OpValid,
   output logic               Busy,
   output logic [CNT_W-1:0]   StepCount,
   output logic               IllegalOp
);

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MUL_STEPS - 1);

   state_t state;
   dec_t   dec;
   logic   ill_q;

   alu_ctrl_decode #(.OP_W(OP_W), .FUNCT_W(FUNCT_W)) u_dec (
      .ALUOp       (ALUOp),
      .ALUFunction (ALUFunction),
      .dec         (dec)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         ALUOperation <= CODE_W'(OP_NOP);
         OpValid      <= 1'b0;
         Busy         <= 1'b0;
         StepCount    <= '0;
         ill_q        <= 1'b0;
      end
      else if (Flush) begin
         state        <= IDLE;
         ALUOperation <= CODE_W'(OP_NOP);
         OpValid      <= 1'b0;
         Busy         <= 1'b0;
         StepCount    <= '0;
      end
      else begin
         case (state)
            // IDLE and MUL_DONE both accept, giving back-to-back issue after MULT.
            IDLE, MUL_DONE: begin
               if (Valid && dec.is_mult) begin
                  state        <= MUL_INIT;
                  ALUOperation <= CODE_W'(OP_MUL_INIT);
                  OpValid      <= 1'b0;
                  Busy         <= 1'b1;
                  StepCount    <= '0;
               end
               else if (Valid) begin
                  state        <= IDLE;
                  ALUOperation <= CODE_W'(dec.code);
                  Busy         <= 1'b0;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
                  OpValid      <= !dec.illegal;
                  ill_q        <= ill_q | dec.illegal;
`else
                  OpValid      <= 1'b1;
`endif
               end
               else begin
                  state        <= IDLE;
                  ALUOperation <= CODE_W'(OP_NOP);
                  OpValid      <= 1'b0;
                  Busy         <= 1'b0;
               end
            end
            MUL_INIT: begin
               state        <= MUL_STEP;
               ALUOperation <= CODE_W'(OP_MUL_STEP);
               StepCount    <= '0;
            end
            MUL_STEP: begin
               if (StepCount == LAST_STEP) begin
                  state        <= MUL_DONE;
                  ALUOperation <= CODE_W'(OP_MUL_DONE);
                  OpValid      <= 1'b1;
                  Busy         <= 1'b0;
               end
               else begin
                  StepCount    <= StepCount + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
   assign IllegalOp = ill_q;
`else
   logic dec_unused;
   assign dec_unused = dec.illegal | ill_q;
   assign IllegalOp  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed self-checking bench for alu_control_seq with MUL_STEPS=4.
module tb_alu_control_seq;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       Valid = 1'b0;
   logic       Flush = 1'b0;
   logic [2:0] ALUOp = '0;
   logic [5:0] ALUFunction = '0;
   logic [3:0] ALUOperation;
   logic       OpValid;
   logic       Busy;
   logic [1:0] StepCount;
   logic       IllegalOp;

   int errors = 0;
   int checks = 0;

   alu_control_seq #(.MUL_STEPS(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .Valid        (Valid),
      .Flush        (Flush),
      .ALUOp        (ALUOp),
      .ALUFunction  (ALUFunction),
      .ALUOperation (ALUOperation),
      .OpValid      (OpValid),
      .Busy         (Busy),
      .StepCount    (StepCount),
      .IllegalOp    (IllegalOp)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] op;
      logic [5:0] fn;
      logic [3:0] code;
      logic       opv;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] fn);
      Valid       = v;
      ALUOp       = op;
      ALUFunction = fn;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string name, input logic [3:0] code, input logic opv,
                          input logic busy, input logic [1:0] cnt);
      chk({name, ".code"}, 32'(ALUOperation), 32'(code));
      chk({name, ".opv"},  32'(OpValid),      32'(opv));
      chk({name, ".busy"}, 32'(Busy),         32'(busy));
      chk({name, ".cnt"},  32'(StepCount),    32'(cnt));
   endtask

   initial begin
      logic exp_ill;
      logic exp_illopv;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      exp_ill    = 1'b1;
      exp_illopv = 1'b0;
`else
      exp_ill    = 1'b0;
      exp_illopv = 1'b1;
`endif
      vecs[0] = '{3'b111, 6'b100100, 4'b0000, 1'b1};
      vecs[1] = '{3'b100, 6'b000000, 4'b0011, 1'b1};
      vecs[2] = '{3'b001, 6'b000000, 4'b0100, 1'b1};
      vecs[3] = '{3'b110, 6'b000000, 4'b1111, 1'b1};
      vecs[4] = '{3'b111, 6'b100101, 4'b0001, 1'b1};
      vecs[5] = '{3'b111, 6'b100111, 4'b0010, 1'b1};
      vecs[6] = '{3'b111, 6'b100000, 4'b0011, 1'b1};
      vecs[7] = '{3'b111, 6'b000001, 4'b1010, 1'b1};
      vecs[8] = '{3'b101, 6'b110011, 4'b0001, 1'b1};

      // reset state
      #12;
      chk_all("reset", 4'b1001, 1'b0, 1'b0, 2'd0);
      chk("reset.ill", 32'(IllegalOp), 32'd0);
      reset = 1'b1;
      tick();
      chk_all("idle", 4'b1001, 1'b0, 1'b0, 2'd0);

      // back-to-back single-cycle decodes
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, vecs[i].op, vecs[i].fn);
         tick();
         chk($sformatf("vec%0d.code", i), 32'(ALUOperation), 32'(vecs[i].code));
         chk($sformatf("vec%0d.opv", i),  32'(OpValid),      32'(vecs[i].opv));
         chk($sformatf("vec%0d.busy", i), 32'(Busy),         32'd0);
      end
      drive(1'b0, 3'b000, 6'b000000);
      tick();
      chk_all("novalid", 4'b1001, 1'b0, 1'b0, 2'd0);

      // MULT sequence; Valid held during busy must be ignored
      drive(1'b1, 3'b111, 6'b011000);
      tick();
      chk_all("minit", 4'b1011, 1'b0, 1'b1, 2'd0);
      drive(1'b1, 3'b111, 6'b100100);
      for (int s = 0; s < 4; s++) begin
         tick();
         chk_all($sformatf("mstep%0d", s), 4'b1010, 1'b0, 1'b1, 2'(s));
      end
      tick();
      chk_all("mdone", 4'b1100, 1'b1, 1'b0, 2'd3);
      // accepted during MUL_DONE with no gap
      drive(1'b1, 3'b111, 6'b100101);
      tick();
      chk_all("b2b", 4'b0001, 1'b1, 1'b0, 2'd3);
      drive(1'b0, 3'b000, 6'b000000);
      tick();
      chk_all("b2b_idle", 4'b1001, 1'b0, 1'b0, 2'd3);

      // flush mid MUL_STEP, together with Valid
      drive(1'b1, 3'b111, 6'b011000);
      tick();
      drive(1'b0, 3'b000, 6'b000000);
      tick();
      tick();
      tick();
      chk_all("pre_flush", 4'b1010, 1'b0, 1'b1, 2'd2);
      Flush = 1'b1;
      drive(1'b1, 3'b111, 6'b100100);
      tick();
      chk_all("flush", 4'b1001, 1'b0, 1'b0, 2'd0);
      Flush = 1'b0;
      drive(1'b0, 3'b000, 6'b000000);
      tick();
      chk_all("flush_drop", 4'b1001, 1'b0, 1'b0, 2'd0);

      // async reset between edges mid MUL_STEP
      drive(1'b1, 3'b111, 6'b011000);
      tick();
      drive(1'b0, 3'b000, 6'b000000);
      tick();
      tick();
      chk("pre_rst.busy", 32'(Busy), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk_all("async_rst", 4'b1001, 1'b0, 1'b0, 2'd0);
      @(negedge clk);
      reset = 1'b1;
      tick();
      chk_all("post_rst", 4'b1001, 1'b0, 1'b0, 2'd0);

      // illegal selector
      drive(1'b1, 3'b000, 6'b000000);
      tick();
      chk("illegal.code", 32'(ALUOperation), 32'h9);
      chk("illegal.opv",  32'(OpValid),      32'(exp_illopv));
      chk("illegal.flag", 32'(IllegalOp),    32'(exp_ill));
      drive(1'b1, 3'b100, 6'b000000);
      tick();
      chk("legal_after.code", 32'(ALUOperation), 32'h3);
      chk("legal_after.opv",  32'(OpValid),      32'd1);
      chk("legal_after.flag", 32'(IllegalOp),    32'(exp_ill));
      drive(1'b0, 3'b000, 6'b000000);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
